// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16-bit unsigned multiply/divide unit.
// Accepts two operands and a destination register index, runs a fixed
// WIDTH-iteration shift-add multiply or restoring divide, then issues a
// single register-file write-back pulse. busy stalls the core meanwhile.
// Build option: define MULDIV_DIV_EN to compile in the divider datapath;
// without it, DIV/REM keep the same timing but write back zero.

module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       dst_addr,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic             busy,
  output logic             w_en,
  output logic [3:0]       addr_c,
  output logic [WIDTH-1:0] data_c,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [3:0]         dst_q;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   result;
  logic               accept;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               partial_hi;
  logic [WIDTH-1:0]   partial_lo;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
`endif

  assign accept = (state == IDLE) && start;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (LSB of the product register) is set.
  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
  end

`ifdef MULDIV_DIV_EN
  // Restoring-divide step on the (WIDTH+1)-bit partial remainder formed by
  // shifting in the next dividend bit; its top bit alone means partial >= divisor.
  always_comb begin
    partial_hi = rem_q[WIDTH-1];
    partial_lo = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    div_ge     = partial_hi | (partial_lo >= b_q);
    rem_next   = div_ge ? (partial_lo - b_q) : partial_lo;
  end
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH cycles, one WB cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == LAST) next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture at acceptance and one arithmetic iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      op_q  <= '0;
      dst_q <= '0;
      a_q   <= '0;
      prod  <= '0;
`ifdef MULDIV_DIV_EN
      b_q   <= '0;
      rem_q <= '0;
      quo_q <= '0;
`endif
    end else if (accept) begin
      count <= '0;
      op_q  <= op;
      dst_q <= dst_addr;
      a_q   <= opnd_a;
      prod  <= {{WIDTH{1'b0}}, opnd_b};
`ifdef MULDIV_DIV_EN
      b_q   <= opnd_b;
      rem_q <= '0;
      quo_q <= opnd_a;
`endif
    end else if (state == RUN) begin
      count <= count + CW'(1);
      prod  <= {mul_sum, prod[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      rem_q <= rem_next;
      quo_q <= {quo_q[WIDTH-2:0], div_ge};
`endif
    end
  end

  // Select the requested result half / quotient / remainder.
  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = prod[WIDTH-1:0];
      2'b01:   result = prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
      2'b10:   result = quo_q;
      2'b11:   result = rem_q;
`else
      2'b10:   result = '0;
      2'b11:   result = '0;
`endif
      default: result = '0;
    endcase
  end

  // Outputs are zero outside WB so the register file never sees a stray write.
  always_comb begin
    busy   = (state != IDLE);
    w_en   = 1'b0;
    done   = 1'b0;
    addr_c = '0;
    data_c = '0;
    if (state == WB) begin
      w_en   = 1'b1;
      done   = 1'b1;
      addr_c = dst_q;
      data_c = result;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit with directed and
// randomized operations compared against an arithmetic reference model.

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  dst_addr;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;
  logic        busy;
  logic        w_en;
  logic [3:0]  addr_c;
  logic [15:0] data_c;
  logic        done;

  int n_compared   = 0;
  int n_mismatched = 0;

  mul_div_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dst_addr (dst_addr),
    .opnd_a   (opnd_a),
    .opnd_b   (opnd_b),
    .busy     (busy),
    .w_en     (w_en),
    .addr_c   (addr_c),
    .data_c   (data_c),
    .done     (done)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference result from plain unsigned arithmetic.
  function automatic logic [15:0] refResult(input logic [1:0] o,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (o)
      2'b00: return p[15:0];
      2'b01: return p[31:16];
`ifdef MULDIV_DIV_EN
      2'b10: return (b == 16'h0) ? 16'hFFFF : a / b;
      2'b11: return (b == 16'h0) ? a : a % b;
`else
      2'b10: return 16'h0000;
      2'b11: return 16'h0000;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Issue one operation, scramble inputs while it runs, optionally pulse
  // start at edge inject_at, and check the write-back and the idle aftermath.
  task automatic applyStimulus(input logic [1:0] o, input logic [3:0] d,
                               input logic [15:0] a, input logic [15:0] b,
                               input int inject_at);
    int n;
    bit seen;
    bit busy_gap;
    int strays;
    logic [15:0] exp_data;
    exp_data = refResult(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; dst_addr = d; opnd_a = a; opnd_b = b;
    @(posedge clk); #1;
    checkOutput("accept_busy", {31'h0, busy}, 32'h1);
    n = 0; seen = 1'b0; busy_gap = 1'b0;
    while (n < 40 && !seen) begin
      opnd_a   = 16'($urandom);
      opnd_b   = 16'($urandom);
      op       = 2'($urandom);
      dst_addr = 4'($urandom);
      start    = (inject_at != 0 && n == inject_at) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      n++;
      if (!busy) busy_gap = 1'b1;
      if (w_en) seen = 1'b1;
    end
    checkOutput("latency", n, 16);
    checkOutput("busy_hold", {31'h0, busy_gap}, 32'h0);
    checkOutput("wb_wen_done", {30'h0, w_en, done}, 32'h3);
    checkOutput("wb_addr", {28'h0, addr_c}, {28'h0, d});
    checkOutput("wb_data", {16'h0, data_c}, {16'h0, exp_data});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("post_wb_idle", {10'h0, busy, w_en, done, addr_c, data_c}, 32'h0);
    strays = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (w_en || busy) strays++;
    end
    checkOutput("no_extra_activity", strays, 0);
  endtask

  // Abort a DIV with reset at its 8th iteration and confirm nothing is written.
  task automatic resetMidOp();
    int strays;
    @(negedge clk);
    start = 1'b1; op = 2'b10; dst_addr = 4'h9; opnd_a = 16'd5000; opnd_b = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset_abort", {10'h0, busy, w_en, done, addr_c, data_c}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    strays = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (w_en || busy) strays++;
    end
    checkOutput("reset_no_wen", strays, 0);
  endtask

  // Hold start high and measure the spacing of consecutive write-backs.
  task automatic backToBack();
    int k;
    int first;
    int second;
    int waited;
    first = -1; second = -1; k = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; dst_addr = 4'h5; opnd_a = 16'd123; opnd_b = 16'd45;
    while (k < 60 && second < 0) begin
      @(posedge clk); #1;
      k++;
      if (w_en) begin
        if (first < 0) begin
          first = k;
          checkOutput("b2b_data", {16'h0, data_c}, 32'd5535);
        end else begin
          second = k;
        end
      end
    end
    checkOutput("b2b_period", second - first, 18);
    start = 1'b0;
    waited = 0;
    while (busy && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("b2b_drain", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; dst_addr = 4'h0;
    opnd_a = 16'h0; opnd_b = 16'h0;
    #12;
    checkOutput("reset_state", {10'h0, busy, w_en, done, addr_c, data_c}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b00, 4'h3, 16'd300, 16'd200, 0);
    applyStimulus(2'b01, 4'h3, 16'd300, 16'd200, 0);
    applyStimulus(2'b01, 4'h7, 16'hFFFF, 16'hFFFF, 0);
    applyStimulus(2'b00, 4'h7, 16'hFFFF, 16'hFFFF, 0);
    applyStimulus(2'b10, 4'hA, 16'd1000, 16'd7, 0);
    applyStimulus(2'b11, 4'hA, 16'd1000, 16'd7, 0);
    applyStimulus(2'b10, 4'h1, 16'h1234, 16'h0000, 0);
    applyStimulus(2'b11, 4'h2, 16'h1234, 16'h0000, 0);
    applyStimulus(2'b00, 4'hC, 16'd4321, 16'd77, 4);

    resetMidOp();
    applyStimulus(2'b00, 4'h4, 16'd2, 16'd3, 0);

    backToBack();

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
      applyStimulus(2'($urandom), 4'($urandom), ra, rb,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
